// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - issue/writeback stage feeding a combinational ALU
// Three-phase IDLE/EXEC/WRITE sequencer around an NREG x BW register file.
module alu_issue_stage #(
   parameter int BW   = 16,
   parameter int NREG = 8,
   localparam int AW  = $clog2(NREG)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [2:0]    cmd_opcode,
   input  logic [AW-1:0] cmd_rd,
   input  logic [AW-1:0] cmd_ra,
   input  logic [AW-1:0] cmd_rb,
   input  logic          cmd_use_imm,
   input  logic [BW-1:0] cmd_imm,
   output logic [BW-1:0] alu_a,
   output logic [BW-1:0] alu_b,
   output logic [2:0]    alu_op,
   input  logic [BW-1:0] alu_out,
   input  logic [2:0]    alu_flags,
   output logic          wb_valid,
   output logic [AW-1:0] wb_rd,
   output logic [BW-1:0] wb_data,
   output logic [2:0]    flags_q,
   output logic          busy,
   input  logic [AW-1:0] dbg_addr,
   output logic [BW-1:0] dbg_data
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      EXEC  = 2'd1,
      WRITE = 2'd2
   } state_t;

   state_t        state;
   logic [BW-1:0] regs [NREG];
   logic [AW-1:0] rd_q;
   logic [2:0]    res_flags;

   assign dbg_data = regs[dbg_addr];

   // wb_data/res_flags double as the captured ALU result, so wb_* hold between writebacks
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_op    <= '0;
         rd_q      <= '0;
         res_flags <= '0;
         wb_valid  <= 1'b0;
         wb_rd     <= '0;
         wb_data   <= '0;
         flags_q   <= '0;
         busy      <= 1'b0;
         cmd_ready <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  alu_a     <= regs[cmd_ra];
                  alu_b     <= cmd_use_imm ? cmd_imm : regs[cmd_rb];
                  alu_op    <= cmd_opcode;
                  rd_q      <= cmd_rd;
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  state     <= EXEC;
               end
            end
            EXEC: begin
               wb_data   <= alu_out;
               res_flags <= alu_flags;
               wb_rd     <= rd_q;
               wb_valid  <= 1'b1;
               state     <= WRITE;
            end
            WRITE: begin
               regs[wb_rd] <= wb_data;
               flags_q     <= res_flags;
               wb_valid    <= 1'b0;
               cmd_ready   <= 1'b1;
               busy        <= 1'b0;
               state       <= IDLE;
            end
            default: begin
               wb_valid  <= 1'b0;
               cmd_ready <= 1'b1;
               busy      <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - randomized and directed checks against a timeline model
// The bench also stands in for the combinational ALU.
module tb_alu_issue_stage;

   localparam int BW = 16;
   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [2:0]    cmd_opcode = '0;
   logic [AW-1:0] cmd_rd = '0, cmd_ra = '0, cmd_rb = '0;
   logic          cmd_use_imm = 1'b0;
   logic [BW-1:0] cmd_imm = '0;
   logic [BW-1:0] alu_a, alu_b, alu_out;
   logic [2:0]    alu_op, alu_flags;
   logic          wb_valid;
   logic [AW-1:0] wb_rd;
   logic [BW-1:0] wb_data;
   logic [2:0]    flags_q;
   logic          busy;
   logic [AW-1:0] dbg_addr = '0;
   logic [BW-1:0] dbg_data;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   alu_issue_stage #(.BW(BW), .NREG(8)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_opcode(cmd_opcode), .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb),
      .cmd_use_imm(cmd_use_imm), .cmd_imm(cmd_imm),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_out(alu_out), .alu_flags(alu_flags),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .flags_q(flags_q), .busy(busy),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ALU: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 not a, 110 pass a, 111 pass b
   function automatic logic [18:0] alu_f(input logic [2:0] op, input logic [15:0] a,
                                         input logic [15:0] b);
      logic [15:0] r;
      logic        ov;
      ov = 1'b0;
      case (op)
         3'd0: begin r = a + b; ov = (a[15] == b[15]) && (r[15] != a[15]); end
         3'd1: begin r = a - b; ov = (a[15] != b[15]) && (r[15] != a[15]); end
         3'd2: r = a & b;
         3'd3: r = a | b;
         3'd4: r = a ^ b;
         3'd5: r = ~a;
         3'd6: r = a;
         default: r = b;
      endcase
      return {ov, r[15], (r == 16'd0), r};
   endfunction

   always_comb {alu_flags, alu_out} = alu_f(alu_op, alu_a, alu_b);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference model: a command accepted at cycle k writes back at k+2 and is
   // architecturally visible from k+3; one command in flight at a time.
   bit          started = 0;
   int          k = 0;
   bit          pend = 0;
   int          pend_at = 0;
   logic [2:0]  p_rd;
   logic [15:0] p_data;
   logic [2:0]  p_flags;
   logic [15:0] mregs [8];
   logic [2:0]  mflags = '0;
   logic [2:0]  m_wb_rd = '0;
   logic [15:0] m_wb_data = '0;
   logic [15:0] m_a = '0, m_b = '0;
   logic [2:0]  m_op = '0;

   always @(negedge clk) begin
      if (started) begin
         chk("cmd_ready", cmd_ready, !pend);
         chk("busy", busy, pend);
         chk("wb_valid", wb_valid, pend && (k == pend_at));
         chk("wb_rd", wb_rd, m_wb_rd);
         chk("wb_data", wb_data, m_wb_data);
         chk("flags_q", flags_q, mflags);
         chk("alu_a", alu_a, m_a);
         chk("alu_b", alu_b, m_b);
         chk("alu_op", alu_op, m_op);
         chk("dbg_data", dbg_data, mregs[dbg_addr]);
         if (rst) begin
            pend = 0;
            for (int i = 0; i < 8; i++) mregs[i] = '0;
            mflags = '0; m_wb_rd = '0; m_wb_data = '0;
            m_a = '0; m_b = '0; m_op = '0;
         end else if (pend && k == pend_at) begin
            mregs[p_rd] = p_data;
            mflags = p_flags;
            pend = 0;
         end else if (pend && k == pend_at - 1) begin
            m_wb_rd = p_rd;
            m_wb_data = p_data;
         end else if (!pend && cmd_valid) begin
            pend = 1;
            pend_at = k + 2;
            p_rd = cmd_rd;
            m_a = mregs[cmd_ra];
            m_b = cmd_use_imm ? cmd_imm : mregs[cmd_rb];
            m_op = cmd_opcode;
            {p_flags, p_data} = alu_f(m_op, m_a, m_b);
         end
         k++;
      end
   end

   // Caller sits just after a rising edge; returns just after the accepting edge.
   task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] ra,
                        input logic [2:0] rb, input bit ui, input logic [15:0] imm,
                        input bit hold, output int acc);
      bit done;
      done = 0;
      acc = -1;
      cmd_opcode = op; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb;
      cmd_use_imm = ui; cmd_imm = imm; cmd_valid = 1'b1;
      for (int i = 0; i < 8 && !done; i++) begin
         @(negedge clk);
         if (cmd_ready) begin
            acc = cyc;
            done = 1;
         end
         @(posedge clk); #1;
      end
      if (!hold) cmd_valid = 1'b0;
      if (!done) begin
         total++; bad++;
         $display("FAIL issue_timeout act=no_accept exp=accept (cycle %0d)", cyc);
      end
   endtask

   task automatic run(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] ra,
                      input logic [2:0] rb, input bit ui, input logic [15:0] imm);
      int acc;
      issue(op, rd, ra, rb, ui, imm, 1'b0, acc);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic peek(input string nm, input logic [2:0] addr, input logic [15:0] exp);
      dbg_addr = addr;
      @(negedge clk);
      chk(nm, dbg_data, exp);
      @(posedge clk); #1;
   endtask

   int acc_t [4];
   int dummy;

   initial begin
      repeat (2) @(posedge clk);
      started = 1;
      @(posedge clk); #1;
      rst = 1'b0;

      // 1: imm loads and ADD
      run(3'd7, 3'd1, 3'd0, 3'd0, 1'b1, 16'd5);
      run(3'd7, 3'd2, 3'd0, 3'd0, 1'b1, 16'd3);
      run(3'd0, 3'd3, 3'd1, 3'd2, 1'b0, 16'd0);
      chk("t1_wb_rd", wb_rd, 3'd3);
      chk("t1_wb_data", wb_data, 16'h0008);
      chk("t1_flags", flags_q, 3'b000);
      peek("t1_r3", 3'd3, 16'd8);

      // 2: signed overflow into negative
      run(3'd7, 3'd1, 3'd0, 3'd0, 1'b1, 16'h7FFF);
      run(3'd0, 3'd4, 3'd1, 3'd0, 1'b1, 16'd1);
      chk("t2_wb_data", wb_data, 16'h8000);
      chk("t2_flags", flags_q, 3'b110);

      // 3: ra==rb subtract to zero, then AND with all-ones
      run(3'd7, 3'd5, 3'd0, 3'd0, 1'b1, 16'h1234);
      run(3'd1, 3'd6, 3'd5, 3'd5, 1'b0, 16'd0);
      chk("t3_sub_data", wb_data, 16'h0000);
      chk("t3_sub_flags", flags_q, 3'b001);
      run(3'd2, 3'd6, 3'd6, 3'd0, 1'b1, 16'hFFFF);
      chk("t3_and_flags", flags_q, 3'b001);

      // 4: back-to-back dependent chain with valid held high
      run(3'd7, 3'd1, 3'd0, 3'd0, 1'b1, 16'd0);
      for (int i = 0; i < 4; i++)
         issue(3'd0, 3'd1, 3'd1, 3'd0, 1'b1, 16'd1, (i < 3), acc_t[i]);
      for (int i = 1; i < 4; i++) chk("t4_spacing", acc_t[i] - acc_t[i-1], 3);
      repeat (2) @(posedge clk); #1;
      peek("t4_r1", 3'd1, 16'd4);

      // 5: reset while the ADD is in EXEC
      issue(3'd0, 3'd7, 3'd1, 3'd2, 1'b0, 16'd0, 1'b0, dummy);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      dbg_addr = 3'd7;
      @(negedge clk);
      chk("t5_ready", cmd_ready, 1'b1);
      chk("t5_r7", dbg_data, 16'd0);
      chk("t5_flags", flags_q, 3'b000);
      @(posedge clk); #1;
      repeat (3) @(posedge clk); #1;

      // 6: command offered only while busy is dropped
      run(3'd7, 3'd5, 3'd0, 3'd0, 1'b1, 16'hAAAA);
      issue(3'd7, 3'd2, 3'd0, 3'd0, 1'b1, 16'd7, 1'b0, dummy);
      cmd_opcode = 3'd7; cmd_rd = 3'd5; cmd_use_imm = 1'b1; cmd_imm = 16'hDEAD;
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      repeat (3) @(posedge clk); #1;
      peek("t6_r5", 3'd5, 16'hAAAA);
      peek("t6_r2", 3'd2, 16'd7);

      // random traffic with occasional resets
      for (int i = 0; i < 800; i++) begin
         rst = ($urandom_range(0, 99) == 0);
         cmd_valid = ($urandom_range(0, 2) != 0);
         cmd_opcode = 3'($urandom_range(0, 7));
         cmd_rd = 3'($urandom_range(0, 7));
         cmd_ra = 3'($urandom_range(0, 7));
         cmd_rb = 3'($urandom_range(0, 7));
         cmd_use_imm = 1'($urandom_range(0, 1));
         cmd_imm = 16'($urandom);
         dbg_addr = 3'($urandom_range(0, 7));
         @(posedge clk); #1;
      end
      rst = 1'b0;
      cmd_valid = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
